// File: rtl/uart_bridge_if.sv
// CPU-side UART parallel handshake: read/write strobes, status flags and the
// low byte of the shared data bus.
interface uart_bridge_if;
    logic       rdn;
    logic       wrn;
    logic [7:0] bus_data_i;
    logic [7:0] bus_data_o;
    logic       bus_data_oe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;

    modport master (
        output rdn, wrn, bus_data_i,
        input  bus_data_o, bus_data_oe, data_ready, tbre, tsre
    );

    modport slave (
        input  rdn, wrn, bus_data_i,
        output bus_data_o, bus_data_oe, data_ready, tbre, tsre
    );
endinterface

// File: rtl/uart_bridge.sv
// Device-side UART responder: CPU writes become 8N1 frames on txd, frames
// received on rxd land in a one-byte buffer the CPU reads back.
module uart_bridge #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           CLK,
    input  logic           RST,
    uart_bridge_if.slave   bus,
    input  logic           rxd,
    output logic           txd,
    output logic           rx_overrun,
    output logic           rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} state_e;

    // Sync chains: bit0 = s1, bit1 = s2, bit2 = edge flop s3
    logic [2:0]    rdn_sync_q, rdn_sync_d, wrn_sync_q, wrn_sync_d, rxd_sync_q, rxd_sync_d;
    logic [23:0]   wdat_q, wdat_d;
    logic [7:0]    hold_q, hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_buf_q, rx_buf_d;
    logic          tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
    logic          data_ready_q, data_ready_d, oe_q, oe_d, ovr_q, ovr_d, ferr_q, ferr_d;
    state_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic          wr_acc_s, rd_clr_s, rx_fall_s, rx_bit_s, rx_done_s, tx_load_s;

    assign wr_acc_s  = wrn_sync_q[1] & ~wrn_sync_q[2];
    assign rd_clr_s  = rdn_sync_q[1] & ~rdn_sync_q[2];
    assign rx_fall_s = ~rxd_sync_q[1] & rxd_sync_q[2];
    assign rx_bit_s  = rxd_sync_q[1];

    // Next-state logic for synchronizers, write/read paths, TX and RX FSMs
    always_comb begin
        rdn_sync_d   = {rdn_sync_q[1:0], bus.rdn};
        wrn_sync_d   = {wrn_sync_q[1:0], bus.wrn};
        rxd_sync_d   = {rxd_sync_q[1:0], rxd};
        wdat_d       = {wdat_q[15:0], bus.bus_data_i};
        hold_d       = hold_q;
        tbre_d       = tbre_q;
        tsre_d       = tsre_q;
        txd_d        = txd_q;
        tx_sh_d      = tx_sh_q;
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        rx_sh_d      = rx_sh_q;
        rx_buf_d     = rx_buf_q;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        data_ready_d = data_ready_q;
        oe_d         = ~rdn_sync_q[1];
        ovr_d        = 1'b0;
        ferr_d       = 1'b0;
        rx_done_s    = 1'b0;
        tx_load_s    = 1'b0;

        // wdat_q[23:16] is the byte sampled in the last low cycle of wrn
        if (wr_acc_s && tbre_q) begin
            hold_d = wdat_q[23:16];
            tbre_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end

        case (tx_state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!tbre_q) begin
                    tx_load_s = 1'b1;
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = {CW{1'b0}};
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_sh_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = {CW{1'b0}};
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q != LAST) begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end else if (!tbre_q) begin
                    tx_load_s = 1'b1;
                end else begin
                    tsre_d     = 1'b1;
                    tx_state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase

        // Shared by IDLE start-up and the gapless STOP-to-START reload
        if (tx_load_s) begin
            tx_sh_d    = hold_q;
            tbre_d     = 1'b1;
            tsre_d     = 1'b0;
            txd_d      = 1'b0;
            tx_cnt_d   = {CW{1'b0}};
            tx_state_d = ST_START;
        end else begin
            tx_sh_d = tx_sh_d;
        end

        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = {CW{1'b0}};
                if (rx_fall_s) begin
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = {CW{1'b0}};
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_bit_s ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d = {CW{1'b0}};
                    rx_sh_d  = {rx_bit_s, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_state_d = ST_IDLE;
                    if (rx_bit_s) begin
                        rx_buf_d  = rx_sh_q;
                        rx_done_s = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase

        // A completing byte beats a same-cycle read clear and suppresses overrun
        if (rx_done_s) begin
            data_ready_d = 1'b1;
            ovr_d        = data_ready_q & ~rd_clr_s;
        end else if (rd_clr_s) begin
            data_ready_d = 1'b0;
        end else begin
            data_ready_d = data_ready_q;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdn_sync_q   <= 3'b111;
            wrn_sync_q   <= 3'b111;
            rxd_sync_q   <= 3'b111;
            wdat_q       <= 24'd0;
            hold_q       <= 8'd0;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            txd_q        <= 1'b1;
            tx_sh_q      <= 8'd0;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= {CW{1'b0}};
            tx_bit_q     <= 3'd0;
            rx_sh_q      <= 8'd0;
            rx_buf_q     <= 8'd0;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= {CW{1'b0}};
            rx_bit_q     <= 3'd0;
            data_ready_q <= 1'b0;
            oe_q         <= 1'b0;
            ovr_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rdn_sync_q   <= rdn_sync_d;
            wrn_sync_q   <= wrn_sync_d;
            rxd_sync_q   <= rxd_sync_d;
            wdat_q       <= wdat_d;
            hold_q       <= hold_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            txd_q        <= txd_d;
            tx_sh_q      <= tx_sh_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            rx_sh_q      <= rx_sh_d;
            rx_buf_q     <= rx_buf_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            data_ready_q <= data_ready_d;
            oe_q         <= oe_d;
            ovr_q        <= ovr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign txd             = txd_q;
    assign rx_overrun      = ovr_q;
    assign rx_frame_err    = ferr_q;
    assign bus.bus_data_o  = rx_buf_q;
    assign bus.bus_data_oe = oe_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.tbre        = tbre_q;
    assign bus.tsre        = tsre_q;
endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge: directed CPU/serial stimulus pushes expected
// TX bytes and RX events; independent monitors decode txd and watch RX outputs.
module tb_uart_bridge;
    localparam int CPB = 8;
    localparam logic [1:0] EV_DATA = 2'd1, EV_OVR = 2'd2, EV_FERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } rx_ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic rxd = 1'b1;
    logic txd, rx_overrun, rx_frame_err;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] tx_exp[$];
    rx_ev_t     rx_exp[$];

    uart_bridge_if bus();

    uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .rxd(rxd), .txd(txd),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.wrn = 1'b0;
        bus.bus_data_i = b;
        repeat (4) @(posedge CLK);
        #1;
        bus.wrn = 1'b1;
        bus.bus_data_i = 8'h00;
    endtask

    task automatic cpu_read(input logic [7:0] exp);
        @(posedge CLK); #1;
        bus.rdn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rd_oe_on", bus.bus_data_oe, 1);
        check("rd_data", bus.bus_data_o, exp);
        @(posedge CLK); #1;
        bus.rdn = 1'b1;
        repeat (3) @(negedge CLK);
        check("rd_ready_before_clear", bus.data_ready, 1);
        @(negedge CLK);
        check("rd_ready_cleared", bus.data_ready, 0);
        check("rd_oe_off", bus.bus_data_oe, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(posedge CLK); #1;
        rxd = 1'b0;
        repeat (CPB) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge CLK);
        end
        #1 rxd = stop_bit;
        repeat (CPB) @(posedge CLK);
        #1 rxd = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    task automatic rx_event(input logic [1:0] kind);
        rx_ev_t e;
        if (rx_exp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_unexpected: got kind %0d data 0x%0h, expected no event", kind, bus.bus_data_o);
        end else begin
            e = rx_exp.pop_front();
            check("rx_event", {22'd0, kind, bus.bus_data_o}, {22'd0, e});
        end
    endtask

    // TX monitor: decode every frame at mid-bit; frames cut by reset are dropped
    initial begin
        logic [7:0] b;
        logic start_bit, stop_bit, abort;
        forever begin
            @(negedge CLK);
            if (RST && txd === 1'b0) begin
                abort = 1'b0;
                repeat (CPB / 2) @(negedge CLK);
                start_bit = txd;
                if (!RST) abort = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = txd;
                    if (!RST) abort = 1'b1;
                end
                repeat (CPB) @(negedge CLK);
                stop_bit = txd;
                if (!RST) abort = 1'b1;
                if (!abort) begin
                    if (tx_exp.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got frame 0x%0h, expected none", b);
                    end else begin
                        check("tx_byte", b, tx_exp.pop_front());
                        check("tx_framing", {start_bit, stop_bit}, 2'b01);
                    end
                end
            end
        end
    end

    // RX monitor: data_ready rising edge and each pulse cycle are events
    initial begin
        logic dr_prev;
        dr_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (rx_overrun)   rx_event(EV_OVR);
                if (rx_frame_err) rx_event(EV_FERR);
                if (bus.data_ready && !dr_prev) rx_event(EV_DATA);
            end
            dr_prev = bus.data_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rdn = 1'b1;
        bus.wrn = 1'b1;
        bus.bus_data_i = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        // Reset / idle state
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        check("rst_flags", {bus.tbre, bus.tsre, bus.data_ready, txd, bus.bus_data_oe}, 5'b11010);
        check("rst_data_o", bus.bus_data_o, 0);
        check("rst_pulses", {rx_overrun, rx_frame_err}, 2'b00);

        // Single write 0xA5 with handshake timing
        tx_exp.push_back(8'hA5);
        cpu_write(8'hA5);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("wr_tbre_edge2", bus.tbre, 1);
        @(negedge CLK);
        check("wr_tbre_edge3", {bus.tbre, bus.tsre, txd}, 3'b011);
        @(negedge CLK);
        check("wr_shift_start", {bus.tbre, bus.tsre, txd}, 3'b100);
        repeat (79) @(negedge CLK);
        check("wr_stop_last", {bus.tsre, txd}, 2'b01);
        @(negedge CLK);
        check("wr_tsre_done", bus.tsre, 1);
        repeat (20) @(posedge CLK);

        // Back-to-back 0x41/0x42, third write dropped
        tx_exp.push_back(8'h41);
        tx_exp.push_back(8'h42);
        fork
            begin
                cpu_write(8'h41);
                repeat (30) @(posedge CLK);
                cpu_write(8'h42);
                repeat (5) @(posedge CLK);
                @(negedge CLK);
                check("b2b_hold_full", bus.tbre, 0);
                cpu_write(8'h43);
            end
            begin
                int g;
                int len;
                g = 0;
                len = 0;
                while (bus.tsre !== 1'b0 && g < 100) begin
                    @(negedge CLK);
                    g++;
                end
                while (bus.tsre === 1'b0 && len < 400) begin
                    @(negedge CLK);
                    len++;
                end
                check("b2b_busy_cycles", len, 2 * 10 * CPB);
            end
        join
        repeat (20) @(posedge CLK);

        // Receive 0x3C then read it
        rx_exp.push_back({EV_DATA, 8'h3C});
        send_rx(8'h3C, 1'b1);
        check("rx_ready_set", bus.data_ready, 1);
        cpu_read(8'h3C);

        // Overrun then framing error
        rx_exp.push_back({EV_DATA, 8'h11});
        send_rx(8'h11, 1'b1);
        rx_exp.push_back({EV_OVR, 8'h22});
        send_rx(8'h22, 1'b1);
        check("ovr_buf", {bus.data_ready, bus.bus_data_o}, {1'b1, 8'h22});
        rx_exp.push_back({EV_FERR, 8'h22});
        send_rx(8'h55, 1'b0);
        check("ferr_buf", bus.bus_data_o, 8'h22);

        // 2-cycle glitch must not produce a byte
        @(posedge CLK); #1;
        rxd = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rxd = 1'b1;
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        check("glitch_buf", {bus.data_ready, bus.bus_data_o}, {1'b1, 8'h22});
        cpu_read(8'h22);

        // Reset in the middle of a TX frame
        cpu_write(8'h77);
        repeat (30) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("rst_mid_tx", {txd, bus.tsre, bus.tbre, bus.data_ready}, 4'b1110);
        repeat (20) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        check("post_rst_idle", {txd, bus.tsre, bus.tbre}, 3'b111);

        begin
            int g;
            g = 0;
            while ((tx_exp.size() != 0 || rx_exp.size() != 0) && g < 3000) begin
                @(negedge CLK);
                g++;
            end
        end
        check("tx_queue_drained", tx_exp.size(), 0);
        check("rx_queue_drained", rx_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
